// File: rtl/ctrl_pkg.sv
// Shared constants and types for the control sequencer: opcodes, FSM states,
// instruction classes and ALU select encodings.
package ctrl_pkg;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_ADDI = 5'b01011;
  localparam logic [4:0] OPC_ANDI = 5'b01100;
  localparam logic [4:0] OPC_ORI  = 5'b01101;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;

  typedef enum logic [2:0] {
    ST_HALT, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/control_seq_decode.sv
// Combinational opcode decoder: opcode -> instruction class, ALU select and
// a legality flag.
module opcode_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = 5,
  parameter int ALUOP_W = 4
) (
  input  logic [OPC_W-1:0]   opcode,
  output op_class_t          op_class,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               legal
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_op   = '0;
    legal    = 1'b1;
    case (opcode)
      OPC_W'(OPC_ADD):  begin op_class = CLS_ALU_R; alu_op = ALUOP_W'(ALU_ADD); end
      OPC_W'(OPC_SUB):  begin op_class = CLS_ALU_R; alu_op = ALUOP_W'(ALU_SUB); end
      OPC_W'(OPC_AND):  begin op_class = CLS_ALU_R; alu_op = ALUOP_W'(ALU_AND); end
      OPC_W'(OPC_OR):   begin op_class = CLS_ALU_R; alu_op = ALUOP_W'(ALU_OR);  end
      OPC_W'(OPC_ADDI): begin op_class = CLS_ALU_I; alu_op = ALUOP_W'(ALU_ADD); end
      OPC_W'(OPC_ANDI): begin op_class = CLS_ALU_I; alu_op = ALUOP_W'(ALU_AND); end
      OPC_W'(OPC_ORI):  begin op_class = CLS_ALU_I; alu_op = ALUOP_W'(ALU_OR);  end
      OPC_W'(OPC_NOP):  op_class = CLS_NOP;
      OPC_W'(OPC_HALT): op_class = CLS_HALT;
      default:          legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_seq.sv
// Hardwired fetch/execute sequencer driving the bus datapath enables, with
// memory-wait handshaking, halt/stop control, illegal trap and retire counter.
module control_seq
  import ctrl_pkg::*;
#(
  parameter int OPC_W         = 5,
  parameter int ALUOP_W       = 4,
  parameter int CNT_W         = 16,
  parameter int USE_MEM_READY = 1
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               Run,
  input  logic               Stop,
  input  logic [31:0]        IR,
  input  logic               MemReady,
  output logic               PCout,
  output logic               Zlowout,
  output logic               MDRout,
  output logic               MARin,
  output logic               Zin,
  output logic               PCin,
  output logic               MDRin,
  output logic               IRin,
  output logic               Yin,
  output logic               IncPC,
  output logic               Read,
  output logic               Gra,
  output logic               Grb,
  output logic               Grc,
  output logic               Rin,
  output logic               Rout,
  output logic               Cout,
  output logic [ALUOP_W-1:0] AluOp,
  output logic               Halted,
  output logic               Illegal,
  output logic [CNT_W-1:0]   Retired
);

  state_t             state_reg, state_next;
  logic               stop_pending_reg, stop_pending_next;
  logic               illegal_reg, illegal_next;
  logic [CNT_W-1:0]   retired_reg, retired_next;
  logic               pc_loaded_reg;

  op_class_t          op_class;
  logic [ALUOP_W-1:0] alu_op;
  logic               legal;
  logic               unused_ir;

  assign unused_ir = ^IR[31-OPC_W:0];

  opcode_decode #(.OPC_W(OPC_W), .ALUOP_W(ALUOP_W)) u_decode (
    .opcode   (IR[31:32-OPC_W]),
    .op_class (op_class),
    .alu_op   (alu_op),
    .legal    (legal)
  );

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_reg        <= ST_HALT;
      stop_pending_reg <= 1'b0;
      illegal_reg      <= 1'b0;
      retired_reg      <= '0;
      pc_loaded_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      stop_pending_reg <= stop_pending_next;
      illegal_reg      <= illegal_next;
      retired_reg      <= retired_next;
      // Remembers that PC was already loaded in an earlier T1 cycle of this fetch.
      pc_loaded_reg    <= (state_reg == ST_T1);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HALT: if (Run) state_next = ST_T0;
      ST_T0:   state_next = ST_T1;
      ST_T1:   if (USE_MEM_READY == 0 || MemReady) state_next = ST_T2;
      ST_T2:   state_next = ST_T3;
      ST_T3: begin
        case (op_class)
          CLS_ALU_R, CLS_ALU_I: state_next = ST_T4;
          CLS_NOP:              state_next = stop_pending_reg ? ST_HALT : ST_T0;
          default:              state_next = ST_HALT;
        endcase
      end
      ST_T4:   state_next = ST_T5;
      ST_T5:   state_next = stop_pending_reg ? ST_HALT : ST_T0;
      default: state_next = ST_HALT;
    endcase
  end

  always_comb begin
    stop_pending_next = stop_pending_reg;
    if (state_next == ST_HALT && state_reg != ST_HALT)
      stop_pending_next = 1'b0;
    else if (Stop && (state_reg != ST_HALT || Run))
      stop_pending_next = 1'b1;

    illegal_next = illegal_reg;
    if (state_reg == ST_HALT && Run)
      illegal_next = 1'b0;
    else if (state_reg == ST_T3 && !legal)
      illegal_next = 1'b1;

    retired_next = retired_reg;
    if (state_reg == ST_T5 || (state_reg == ST_T3 && op_class == CLS_NOP))
      retired_next = retired_reg + CNT_W'(1);
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; MARin = 1'b0; Zin = 1'b0;
    PCin  = 1'b0; MDRin   = 1'b0; IRin   = 1'b0; Yin   = 1'b0; IncPC = 1'b0;
    Read  = 1'b0; Gra     = 1'b0; Grb    = 1'b0; Grc   = 1'b0; Rin = 1'b0;
    Rout  = 1'b0; Cout    = 1'b0;
    AluOp = '0;
    case (state_reg)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = !pc_loaded_reg;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        if (op_class == CLS_ALU_R || op_class == CLS_ALU_I) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
      end
      ST_T4: begin
        Zin   = 1'b1;
        AluOp = alu_op;
        if (op_class == CLS_ALU_R) begin
          Grc = 1'b1; Rout = 1'b1;
        end else begin
          Cout = 1'b1;
        end
      end
      ST_T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      default: ;
    endcase
  end

  assign Halted  = (state_reg == ST_HALT);
  assign Illegal = illegal_reg;
  assign Retired = retired_reg;

endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: directed scenarios plus random instruction streams
// compared cycle by cycle against a per-instruction strobe schedule model.
module tb_control_seq;
  import ctrl_pkg::*;

  logic        Clock = 1'b0;
  logic        Clear, Run, Stop, MemReady;
  logic [31:0] IR;
  logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC;
  logic Read, Gra, Grb, Grc, Rin, Rout, Cout, Halted, Illegal;
  logic [3:0]  AluOp;
  logic [15:0] Retired;

  logic        Run2, Stop2, MemReady2;
  logic [31:0] IR2;
  logic s2_pcout, s2_zlowout, s2_mdrout, s2_marin, s2_zin, s2_pcin, s2_mdrin, s2_irin, s2_yin;
  logic s2_incpc, s2_read, s2_gra, s2_grb, s2_grc, s2_rin, s2_rout, s2_cout, Halted2, Illegal2;
  logic [3:0]  AluOp2;
  logic [1:0]  Retired2;

  always #5 Clock = ~Clock;

  control_seq dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .Stop(Stop), .IR(IR), .MemReady(MemReady),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .Cout(Cout),
    .AluOp(AluOp), .Halted(Halted), .Illegal(Illegal), .Retired(Retired)
  );

  control_seq #(.CNT_W(2), .USE_MEM_READY(0)) dut2 (
    .Clock(Clock), .Clear(Clear), .Run(Run2), .Stop(Stop2), .IR(IR2), .MemReady(MemReady2),
    .PCout(s2_pcout), .Zlowout(s2_zlowout), .MDRout(s2_mdrout), .MARin(s2_marin), .Zin(s2_zin),
    .PCin(s2_pcin), .MDRin(s2_mdrin), .IRin(s2_irin), .Yin(s2_yin), .IncPC(s2_incpc), .Read(s2_read),
    .Gra(s2_gra), .Grb(s2_grb), .Grc(s2_grc), .Rin(s2_rin), .Rout(s2_rout), .Cout(s2_cout),
    .AluOp(AluOp2), .Halted(Halted2), .Illegal(Illegal2), .Retired(Retired2)
  );

  logic [16:0] strobes, strobes2;
  assign strobes  = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC,
                     Read, Gra, Grb, Grc, Rin, Rout, Cout};
  assign strobes2 = {s2_pcout, s2_zlowout, s2_mdrout, s2_marin, s2_zin, s2_pcin, s2_mdrin,
                     s2_irin, s2_yin, s2_incpc, s2_read, s2_gra, s2_grb, s2_grc, s2_rin,
                     s2_rout, s2_cout};

  localparam logic [16:0] M_PCOUT = 17'd1 << 16, M_ZLOW = 17'd1 << 15, M_MDROUT = 17'd1 << 14;
  localparam logic [16:0] M_MARIN = 17'd1 << 13, M_ZIN  = 17'd1 << 12, M_PCIN   = 17'd1 << 11;
  localparam logic [16:0] M_MDRIN = 17'd1 << 10, M_IRIN = 17'd1 << 9,  M_YIN    = 17'd1 << 8;
  localparam logic [16:0] M_INCPC = 17'd1 << 7,  M_READ = 17'd1 << 6,  M_GRA    = 17'd1 << 5;
  localparam logic [16:0] M_GRB   = 17'd1 << 4,  M_GRC  = 17'd1 << 3,  M_RIN    = 17'd1 << 2;
  localparam logic [16:0] M_ROUT  = 17'd1 << 1,  M_COUT = 17'd1;

  logic [4:0] ops [12];
  int  n_checks = 0;
  int  n_fail = 0;
  int  m_retired = 0;
  bit  m_illegal = 0, m_halted = 1, m_pend = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 register ALU, 1 immediate ALU, 2 NOP, 3 HALT, 4 undefined
  task automatic classify(input logic [4:0] op, output int kind, output logic [3:0] aop);
    kind = 4; aop = 4'd0;
    if (op == OPC_ADD)       begin kind = 0; aop = 4'd1; end
    else if (op == OPC_SUB)  begin kind = 0; aop = 4'd2; end
    else if (op == OPC_AND)  begin kind = 0; aop = 4'd3; end
    else if (op == OPC_OR)   begin kind = 0; aop = 4'd4; end
    else if (op == OPC_ADDI) begin kind = 1; aop = 4'd1; end
    else if (op == OPC_ANDI) begin kind = 1; aop = 4'd3; end
    else if (op == OPC_ORI)  begin kind = 1; aop = 4'd4; end
    else if (op == OPC_NOP)  kind = 2;
    else if (op == OPC_HALT) kind = 3;
  endtask

  task automatic start(input bit with_stop);
    check("halted_idle", {31'd0, Halted}, 32'd1);
    check("idle_strobes", {15'd0, strobes}, 32'd0);
    Run = 1'b1; Stop = with_stop;
    @(negedge Clock);
    Run = 1'b0; Stop = 1'b0;
    m_halted = 0; m_illegal = 0;
    if (with_stop) m_pend = 1;
    check("illegal_cleared", {31'd0, Illegal}, 32'd0);
  endtask

  // Runs one instruction that starts in T0; stop_mode -1 none, -2 random, else the cycle index of a Stop pulse.
  task automatic exec(input logic [31:0] ir, input int waits, input int stop_mode);
    logic [16:0] ew[$];
    logic [3:0]  eo[$];
    int          kind, stop_k, cycles;
    logic [3:0]  aop;
    classify(ir[31:27], kind, aop);
    ew.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN); eo.push_back(4'd0);
    for (int w = 0; w <= waits; w++) begin
      ew.push_back(M_ZLOW | M_READ | M_MDRIN | ((w == 0) ? M_PCIN : 17'd0)); eo.push_back(4'd0);
    end
    ew.push_back(M_MDROUT | M_IRIN); eo.push_back(4'd0);
    ew.push_back((kind <= 1) ? (M_GRB | M_ROUT | M_YIN) : 17'd0); eo.push_back(4'd0);
    if (kind <= 1) begin
      ew.push_back((kind == 0) ? (M_GRC | M_ROUT | M_ZIN) : (M_COUT | M_ZIN)); eo.push_back(aop);
      ew.push_back(M_ZLOW | M_GRA | M_RIN); eo.push_back(4'd0);
    end
    cycles = ew.size();
    stop_k = stop_mode;
    if (stop_mode == -2)
      stop_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cycles - 2)) : -1;
    for (int k = 0; k < cycles; k++) begin
      check("strobes", {15'd0, strobes}, {15'd0, ew[k]});
      check("aluop", {28'd0, AluOp}, {28'd0, eo[k]});
      check("halted_busy", {31'd0, Halted}, 32'd0);
      if (k < 2) IR = $urandom();
      else if (k == 2) IR = ir;
      MemReady = !(k >= 1 && k <= waits);
      Stop = (k == stop_k);
      @(negedge Clock);
    end
    Stop = 1'b0; MemReady = 1'b1;
    if (stop_k >= 0) m_pend = 1;
    if (kind <= 2) m_retired++;
    if (kind == 4) m_illegal = 1;
    if (kind >= 3 || m_pend) begin m_halted = 1; m_pend = 0; end
    $display("instr ir=%08h waits=%0d stop_k=%0d cycles=%0d retired=%0d halted=%0d",
             ir, waits, stop_k, cycles, Retired, Halted);
    check("retired", {16'd0, Retired}, m_retired % 65536);
    check("illegal", {31'd0, Illegal}, {31'd0, m_illegal});
    check("halted_after", {31'd0, Halted}, {31'd0, m_halted});
  endtask

  initial begin
    logic [31:0] r;
    ops = '{OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ADDI, OPC_ANDI, OPC_ORI,
            OPC_NOP, OPC_HALT, 5'b11111, 5'b00000, 5'b10101};
    Clear = 1'b1; Run = 1'b0; Stop = 1'b0; MemReady = 1'b1; IR = 32'd0;
    Run2 = 1'b0; Stop2 = 1'b0; MemReady2 = 1'b0; IR2 = {OPC_NOP, 27'd0};
    repeat (2) @(negedge Clock);
    check("rst_strobes", {15'd0, strobes}, 32'd0);
    check("rst_aluop", {28'd0, AluOp}, 32'd0);
    check("rst_halted", {31'd0, Halted}, 32'd1);
    check("rst_illegal", {31'd0, Illegal}, 32'd0);
    check("rst_retired", {16'd0, Retired}, 32'd0);
    Clear = 1'b0;
    @(negedge Clock);

    start(1'b1);                    // Run with Stop: exactly one instruction
    exec(32'h590FFFFB, 0, -1);
    start(1'b0);
    exec(32'h590FFFFB, 3, -1);      // three memory wait cycles
    exec({OPC_ADD, 27'h0443000}, 0, 2);
    start(1'b0);
    exec(32'hD8000000, 0, -1);      // HALT opcode
    start(1'b0);
    exec(32'hF8000000, 1, -1);      // undefined opcode
    start(1'b1);
    exec({OPC_NOP, 27'd0}, 0, -1);

    // Clear in the middle of T4 of an ADD
    IR = {OPC_ADD, 27'd0};
    start(1'b0);
    repeat (4) @(negedge Clock);
    check("clr_pre_aluop", {28'd0, AluOp}, 32'd1);
    #2 Clear = 1'b1;
    #1;
    check("clr_strobes", {15'd0, strobes}, 32'd0);
    check("clr_rin", {31'd0, Rin}, 32'd0);
    check("clr_aluop", {28'd0, AluOp}, 32'd0);
    check("clr_halted", {31'd0, Halted}, 32'd1);
    check("clr_retired", {16'd0, Retired}, 32'd0);
    @(negedge Clock);
    Clear = 1'b0;
    m_retired = 0; m_illegal = 0; m_halted = 1; m_pend = 0;
    @(negedge Clock);

    for (int i = 0; i < 60; i++) begin
      if (m_halted) start($urandom_range(0, 4) == 0);
      r = $urandom();
      exec({ops[$urandom_range(0, 11)], r[26:0]}, int'($urandom_range(0, 3)), -2);
    end

    // Narrow counter, MemReady ignored: five NOPs wrap the count to 1
    check("w_halted_idle", {31'd0, Halted2}, 32'd1);
    Run2 = 1'b1;
    @(negedge Clock);
    Run2 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("w_halted_busy", {31'd0, Halted2}, 32'd0);
      Stop2 = (k == 16);
      @(negedge Clock);
    end
    Stop2 = 1'b0;
    $display("wrap test retired=%0d halted=%0d", Retired2, Halted2);
    check("w_halted", {31'd0, Halted2}, 32'd1);
    check("w_retired", {30'd0, Retired2}, 32'd1);
    check("w_strobes", {15'd0, strobes2}, 32'd0);
    check("w_aluop_illegal", {27'd0, AluOp2, Illegal2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
